// File: rtl/segment_walker_if.sv
// Glyph-walker bus: start/status, glyph ROM fetch port and the point stream.
// The master side is the walker; the slave side is the ROM plus point consumer.
interface segment_walker_if;
    logic       start;
    logic [4:0] seg_count;
    logic       busy;
    logic       done;

    logic [4:0] idx;
    logic       rom_en;
    logic [7:0] start_x;
    logic [7:0] start_y;
    logic [7:0] end_x;
    logic [7:0] end_y;
    logic       pen_in;

    logic [7:0] pt_x;
    logic [7:0] pt_y;
    logic       pt_pen;
    logic       pt_valid;
    logic       pt_ready;

    modport master (
        input  start, seg_count, start_x, start_y, end_x, end_y, pen_in, pt_ready,
        output busy, done, idx, rom_en, pt_x, pt_y, pt_pen, pt_valid
    );

    modport slave (
        output start, seg_count, start_x, start_y, end_x, end_y, pen_in, pt_ready,
        input  busy, done, idx, rom_en, pt_x, pt_y, pt_pen, pt_valid
    );
endinterface

// File: rtl/segment_walker.sv
// Walks a glyph segment list from a ROM and rasterises each segment with Bresenham.
// Define SEGMENT_WALKER_PEN_SETTLE_EN to insert PEN_SETTLE idle cycles on every pen change.
module segment_walker #(
    parameter int PEN_SETTLE = 16
) (
    input  logic              clk,
    input  logic              rst,
    segment_walker_if.master  bus
);

    localparam int SETTLE_W = (PEN_SETTLE > 1) ? $clog2(PEN_SETTLE) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, SETTLE, STEP, NEXT} state_t;

    state_t state;
    state_t state_next;

    logic [4:0]          idx;
    logic [4:0]          seg_num;
    logic [7:0]          x;
    logic [7:0]          y;
    logic [7:0]          ex;
    logic [7:0]          ey;
    logic                sx_neg;
    logic                sy_neg;
    logic                pen;
    logic                done_r;
    logic signed [9:0]   dx;
    logic signed [9:0]   dy;
    logic signed [9:0]   err;
    logic [SETTLE_W-1:0] settle_cnt;
`ifdef SEGMENT_WALKER_PEN_SETTLE_EN
    logic                prev_pen;
`endif

    logic signed [9:0]   dx_f;
    logic signed [9:0]   dy_f;
    logic signed [10:0]  e2;
    logic                step_x;
    logic                step_y;
    logic signed [9:0]   err_next;
    logic [7:0]          x_next;
    logic [7:0]          y_next;
    logic                at_end;
    logic                last_seg;
    logic                accept;
    logic                need_settle;

    function automatic logic signed [9:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        logic signed [9:0] d;
        d = $signed({2'b00, a}) - $signed({2'b00, b});
        return (d < 0) ? -d : d;
    endfunction

    assign dx_f = abs_diff(bus.end_x, bus.start_x);
    assign dy_f = -abs_diff(bus.end_y, bus.start_y);

    // Both axis decisions use the same pre-update error term.
    assign e2       = {err, 1'b0};
    assign step_x   = (e2 >= dy);
    assign step_y   = (e2 <= dx);
    assign err_next = err + (step_x ? dy : 10'sd0) + (step_y ? dx : 10'sd0);
    assign x_next   = step_x ? (sx_neg ? x - 8'd1 : x + 8'd1) : x;
    assign y_next   = step_y ? (sy_neg ? y - 8'd1 : y + 8'd1) : y;

    assign at_end   = (x == ex) && (y == ey);
    assign last_seg = (idx == seg_num - 5'd1);
    assign accept   = bus.start && (bus.seg_count != 5'd0);

`ifdef SEGMENT_WALKER_PEN_SETTLE_EN
    assign need_settle = (bus.pen_in != prev_pen) && (PEN_SETTLE > 0);
`else
    assign need_settle = 1'b0;
`endif

    assign bus.idx    = idx;
    assign bus.pt_x   = x;
    assign bus.pt_y   = y;
    assign bus.pt_pen = pen;
    assign bus.done   = done_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        bus.rom_en   = 1'b0;
        bus.pt_valid = 1'b0;
        bus.busy     = (state != IDLE);
        case (state)
            IDLE:   if (accept) state_next = FETCH;
            FETCH: begin
                bus.rom_en = 1'b1;
                state_next = need_settle ? SETTLE : STEP;
            end
            SETTLE: if (settle_cnt == '0) state_next = STEP;
            STEP: begin
                bus.pt_valid = 1'b1;
                if (bus.pt_ready && at_end) state_next = NEXT;
            end
            NEXT:   state_next = last_seg ? IDLE : FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            seg_num    <= '0;
            x          <= '0;
            y          <= '0;
            ex         <= '0;
            ey         <= '0;
            sx_neg     <= 1'b0;
            sy_neg     <= 1'b0;
            pen        <= 1'b0;
            done_r     <= 1'b0;
            dx         <= '0;
            dy         <= '0;
            err        <= '0;
            settle_cnt <= '0;
`ifdef SEGMENT_WALKER_PEN_SETTLE_EN
            prev_pen   <= 1'b0;
`endif
        end else begin
            done_r <= (state == IDLE && bus.start && bus.seg_count == 5'd0) ||
                      (state == NEXT && last_seg);
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx     <= '0;
                        seg_num <= bus.seg_count;
`ifdef SEGMENT_WALKER_PEN_SETTLE_EN
                        prev_pen <= 1'b0;
`endif
                    end
                end
                FETCH: begin
                    x      <= bus.start_x;
                    y      <= bus.start_y;
                    ex     <= bus.end_x;
                    ey     <= bus.end_y;
                    pen    <= bus.pen_in;
                    sx_neg <= (bus.end_x < bus.start_x);
                    sy_neg <= (bus.end_y < bus.start_y);
                    dx     <= dx_f;
                    dy     <= dy_f;
                    err    <= dx_f + dy_f;
`ifdef SEGMENT_WALKER_PEN_SETTLE_EN
                    prev_pen <= bus.pen_in;
                    if (need_settle) settle_cnt <= SETTLE_W'(PEN_SETTLE - 1);
`endif
                end
                SETTLE: settle_cnt <= settle_cnt - 1'b1;
                STEP: begin
                    // The endpoint handshake leaves the point in place; NEXT takes over.
                    if (bus.pt_ready && !at_end) begin
                        x   <= x_next;
                        y   <= y_next;
                        err <= err_next;
                    end
                end
                NEXT: idx <= last_seg ? 5'd0 : idx + 5'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_segment_walker.sv
// Self-checking bench for segment_walker: vector table, rectangle glyph, random glyphs,
// back-pressure, reset mid-segment, zero-length glyph and start-while-busy.
module tb_segment_walker;
    localparam int PEN_SETTLE = 16;
`ifdef SEGMENT_WALKER_PEN_SETTLE_EN
    localparam int SETTLE_LEN = PEN_SETTLE;
`else
    localparam int SETTLE_LEN = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    segment_walker_if bus();
    segment_walker #(.PEN_SETTLE(PEN_SETTLE)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    logic [7:0] rom_sx [32];
    logic [7:0] rom_sy [32];
    logic [7:0] rom_ex [32];
    logic [7:0] rom_ey [32];
    logic       rom_pen[32];

    assign bus.start_x = bus.rom_en ? rom_sx[bus.idx] : 8'h00;
    assign bus.start_y = bus.rom_en ? rom_sy[bus.idx] : 8'h00;
    assign bus.end_x   = bus.rom_en ? rom_ex[bus.idx] : 8'h00;
    assign bus.end_y   = bus.rom_en ? rom_ey[bus.idx] : 8'h00;
    assign bus.pen_in  = bus.rom_en ? rom_pen[bus.idx] : 1'b0;

    typedef struct {
        int sx; int sy; int ex; int ey; int pen; int npts;
    } vec_t;

    int passed = 0;
    int total  = 0;
    int cap_q[$];
    int exp_q[$];
    int gap_q[$];
    int exp_gap_q[$];
    int exp_first;
    int done_cnt, stall_bad, low_run, held_pt;
    bit prev_valid, prev_ready, seen_hs, rand_ready;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    function automatic int pack(input int x, input int y, input int p);
        return (p << 16) | (x << 8) | y;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: each segment rasterised independently with integer Bresenham.
    task automatic build_expected(input int nseg);
        int prev_pen;
        exp_q.delete();
        exp_gap_q.delete();
        prev_pen = 0;
        for (int s = 0; s < nseg; s++) begin
            int x, y, x1, y1, dx, dy, sx, sy, err, e2, settle, guard;
            x = rom_sx[s]; y = rom_sy[s]; x1 = rom_ex[s]; y1 = rom_ey[s];
            dx = iabs(x1 - x); dy = -iabs(y1 - y);
            sx = (x1 >= x) ? 1 : -1; sy = (y1 >= y) ? 1 : -1;
            err = dx + dy;
            settle = (int'(rom_pen[s]) != prev_pen) ? SETTLE_LEN : 0;
            prev_pen = rom_pen[s];
            if (s == 0) exp_first = 2 + settle;
            else exp_gap_q.push_back(2 + settle);
            guard = 0;
            while (guard < 600) begin
                exp_q.push_back(pack(x, y, rom_pen[s]));
                if (x == x1 && y == y1) break;
                e2 = 2 * err;
                if (e2 >= dy) begin err += dy; x += sx; end
                if (e2 <= dx) begin err += dx; y += sy; end
                guard++;
            end
        end
    endtask

    task automatic sample();
        int pt;
        pt = pack(bus.pt_x, bus.pt_y, bus.pt_pen);
        if (prev_valid && !prev_ready && (!bus.pt_valid || pt != held_pt)) stall_bad++;
        if (bus.pt_valid && !prev_valid && seen_hs) gap_q.push_back(low_run);
        low_run = bus.pt_valid ? 0 : low_run + 1;
        if (bus.pt_valid && bus.pt_ready) begin
            cap_q.push_back(pt);
            seen_hs = 1'b1;
        end
        if (bus.done) done_cnt++;
        prev_valid = bus.pt_valid;
        prev_ready = bus.pt_ready;
        held_pt    = pt;
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic advance();
        @(negedge clk);
        bus.pt_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        sample();
    endtask

    task automatic clear_monitor();
        cap_q.delete();
        gap_q.delete();
        done_cnt = 0; stall_bad = 0; low_run = 0;
        seen_hs = 1'b0; prev_valid = 1'b0; prev_ready = 1'b1;
    endtask

    task automatic compare_queues(input string name, input int got[$], input int want[$]);
        int bad;
        check({name, " size"}, got.size(), want.size());
        bad = -1;
        for (int i = 0; i < got.size() && i < want.size(); i++) begin
            if (bad < 0 && got[i] != want[i]) begin
                bad = i;
                $display("  %s differs at %0d: got %h want %h", name, i, got[i], want[i]);
            end
        end
        check({name, " first bad index"}, bad, -1);
    endtask

    task automatic run_glyph(input string tag, input int nseg, input bit rnd, input int inject_at);
        int lat, n;
        bit injected;
        build_expected(nseg);
        clear_monitor();
        rand_ready = rnd;
        bus.seg_count = 5'(nseg);
        bus.start = 1'b1;
        advance();
        bus.start = 1'b0;
        check({tag, " fetch rom_en"}, bus.rom_en, 1);
        check({tag, " fetch idx"}, bus.idx, 0);
        check({tag, " busy"}, bus.busy, 1);
        lat = 1;
        while (!bus.pt_valid && lat < 200) begin
            advance();
            lat++;
        end
        check({tag, " first pt latency"}, lat, exp_first);
        n = 0;
        injected = 1'b0;
        while (done_cnt == 0 && n < 20000) begin
            advance();
            n++;
            if (inject_at >= 0 && !injected && cap_q.size() >= inject_at) begin
                bus.seg_count = 5'd1;
                bus.start = 1'b1;
                advance();
                bus.start = 1'b0;
                injected = 1'b1;
            end
        end
        check({tag, " done seen"}, (done_cnt > 0) ? 1 : 0, 1);
        repeat (3) advance();
        check({tag, " done pulses"}, done_cnt, 1);
        check({tag, " busy after done"}, bus.busy, 0);
        check({tag, " stall hold violations"}, stall_bad, 0);
        compare_queues({tag, " points"}, cap_q, exp_q);
        compare_queues({tag, " gaps"}, gap_q, exp_gap_q);
    endtask

    task automatic load_seg(input int s, input int sx, input int sy, input int ex, input int ey, input int pen);
        rom_sx[s] = 8'(sx); rom_sy[s] = 8'(sy); rom_ex[s] = 8'(ex); rom_ey[s] = 8'(ey);
        rom_pen[s] = (pen != 0);
    endtask

    task automatic load_rect();
        load_seg(0,   0,   0,  60,  40, 0);
        load_seg(1,  60,  40, 180,  40, 1);
        load_seg(2, 180,  40, 180, 120, 1);
        load_seg(3, 180, 120,  60, 120, 1);
        load_seg(4,  60, 120,  60,  40, 1);
        load_seg(5,  60,  40,   0,   0, 0);
    endtask

    initial begin
        vec_t tbl[7];
        int want[4];
        int v, n;

        tbl[0] = '{sx:0,   sy:0,   ex:3,   ey:1,  pen:1, npts:4};
        tbl[1] = '{sx:5,   sy:5,   ex:5,   ey:5,  pen:0, npts:1};
        tbl[2] = '{sx:10,  sy:20,  ex:10,  ey:2,  pen:1, npts:19};
        tbl[3] = '{sx:200, sy:7,   ex:190, ey:30, pen:0, npts:24};
        tbl[4] = '{sx:0,   sy:255, ex:255, ey:0,  pen:1, npts:256};
        tbl[5] = '{sx:255, sy:0,   ex:0,   ey:0,  pen:0, npts:256};
        tbl[6] = '{sx:7,   sy:9,   ex:3,   ey:9,  pen:1, npts:5};

        for (int i = 0; i < 32; i++) load_seg(i, 0, 0, 0, 0, 0);
        rst = 1'b1;
        bus.start = 1'b0;
        bus.seg_count = 5'd0;
        bus.pt_ready = 1'b1;
        rand_ready = 1'b0;
        clear_monitor();
        repeat (3) @(negedge clk);
        check("reset idx", bus.idx, 0);
        check("reset rom_en", bus.rom_en, 0);
        check("reset pt_valid", bus.pt_valid, 0);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset point", pack(bus.pt_x, bus.pt_y, bus.pt_pen), 0);
        rst = 1'b0;
        advance();

        for (int i = 0; i < 7; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            load_seg(0, tbl[i].sx, tbl[i].sy, tbl[i].ex, tbl[i].ey, tbl[i].pen);
            run_glyph(tag, 1, (i % 2) == 1, -1);
            check({tag, " point count"}, cap_q.size(), tbl[i].npts);
        end

        load_seg(0, 0, 0, 3, 1, 1);
        run_glyph("line31", 1, 1'b0, -1);
        want[0] = pack(0, 0, 1); want[1] = pack(1, 0, 1);
        want[2] = pack(2, 1, 1); want[3] = pack(3, 1, 1);
        for (int j = 0; j < 4; j++)
            check($sformatf("line31 pt%0d", j), (j < cap_q.size()) ? cap_q[j] : -1, want[j]);

        load_rect();
        run_glyph("rect", 6, 1'b0, -1);
        check("rect handshakes", cap_q.size(), 526);
        run_glyph("rect_bp", 6, 1'b1, 300);
        check("rect_bp handshakes", cap_q.size(), 526);

        // Reset while drawing point 50 of segment 1.
        clear_monitor();
        rand_ready = 1'b0;
        bus.seg_count = 5'd6;
        bus.start = 1'b1;
        advance();
        bus.start = 1'b0;
        n = 0;
        while (cap_q.size() < 111 && n < 2000) begin advance(); n++; end
        check("mid reset reached", cap_q.size(), 111);
        rst = 1'b1;
        #1;
        check("async rst idx", bus.idx, 0);
        check("async rst point", pack(bus.pt_x, bus.pt_y, bus.pt_pen), 0);
        check("async rst pt_valid", bus.pt_valid, 0);
        check("async rst rom_en", bus.rom_en, 0);
        check("async rst busy", bus.busy, 0);
        check("async rst done", bus.done, 0);
        advance();
        advance();
        rst = 1'b0;
        advance();
        run_glyph("rect_after_rst", 6, 1'b0, -1);
        check("restart first point", (cap_q.size() > 0) ? cap_q[0] : -1, pack(0, 0, 0));

        // Empty glyph.
        clear_monitor();
        bus.seg_count = 5'd0;
        bus.start = 1'b1;
        advance();
        bus.start = 1'b0;
        check("empty done", bus.done, 1);
        check("empty busy", bus.busy, 0);
        check("empty pt_valid", bus.pt_valid, 0);
        advance();
        check("empty done width", bus.done, 0);
        v = 0;
        repeat (4) begin advance(); if (bus.pt_valid || bus.rom_en) v++; end
        check("empty no activity", v, 0);

        for (int g = 0; g < 6; g++) begin
            int nseg;
            nseg = $urandom_range(1, 5);
            for (int s = 0; s < nseg; s++)
                load_seg(s, $urandom_range(0, 255), $urandom_range(0, 255),
                         $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
            run_glyph($sformatf("rand%0d", g), nseg, 1'b1, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
